// File: rtl/cvt16to9.sv
// cvt16to9 -- repacks a 16-bit, bit-count-qualified packet stream into
// 9-bit output words. Input bits are accumulated MSB-first in a BUF_W-bit
// buffer; full words are emitted as soon as they exist and one final
// (possibly partial or empty) word closes each packet.
//
// Optional build macro: CVT16TO9_STATS_EN adds the pkt_cnt / err_cnt
// statistic outputs. Without it the datapath is unchanged and the ports
// do not exist.
//
// Buffer invariant: bits of buf_q below the cnt_q valid bits are always
// zero (input beats are masked and every shift fills with zeros), so a
// partial final word needs no extra cleanup; it is masked anyway.

module cvt16to9 #(
   parameter int BUF_W = 32,
   parameter int OUT_W = 9
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [15:0]      data_in,
   input  logic             data_in_valid,
   input  logic             data_in_sop,
   input  logic             data_in_eop,
   input  logic [4:0]       data_in_valid_bits,
   output logic             data_in_ready,
   output logic [OUT_W-1:0] data_out,
   output logic             data_out_valid,
   input  logic             data_out_ready,
   output logic             data_out_sop,
   output logic             data_out_eop,
   output logic [3:0]       data_out_valid_bits
`ifdef CVT16TO9_STATS_EN
   ,
   output logic [15:0]      pkt_cnt,
   output logic [15:0]      err_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [5:0] WORD_BITS = 6'(OUT_W);

   // Mask keeping the top n bits of an output word (all bits when n >= OUT_W).
   function automatic logic [OUT_W-1:0] top_mask(input logic [5:0] n);
      logic [OUT_W-1:0] m;
      if (n >= WORD_BITS) begin
         m = {OUT_W{1'b1}};
      end else begin
         m = ~({OUT_W{1'b1}} >> n);
      end
      return m;
   endfunction

   // State and storage
   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [BUF_W-1:0]  buf_q, buf_d;
   logic              first_q, first_d;

   // Output word register
   logic [OUT_W-1:0]  dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              dout_sop_q, dout_sop_d;
   logic              dout_eop_q, dout_eop_d;
   logic [3:0]        dout_vb_q, dout_vb_d;

   // Control / datapath signals
   logic [4:0]        vb_clamp_s;
   logic [15:0]       in_bits_s;
   logic              in_ready_s;
   logic              in_fire_s;
   logic              slot_free_s;
   logic              pop_full_s;
   logic              pop_last_s;
   logic              load_s;
   logic              push_s;
   logic              sop_set_s;
   logic [5:0]        pop_n_s;
   logic [5:0]        cnt_rem_s;
   logic [5:0]        push_n_s;
   logic [BUF_W-1:0]  buf_rem_s;
   logic [BUF_W-1:0]  in_ext_s;
   logic [OUT_W-1:0]  word_top_s;

   // Input qualification: clamp the bit count, mask off bits past it.
   always_comb begin
      if (data_in_valid_bits > 5'd16) begin
         vb_clamp_s = 5'd16;
      end else begin
         vb_clamp_s = data_in_valid_bits;
      end
      in_bits_s   = data_in & ~(16'hFFFF >> vb_clamp_s);
      in_ready_s  = (state_q != ST_FLUSH) && (cnt_q <= 6'd16);
      in_fire_s   = data_in_valid && in_ready_s;
      slot_free_s = !dout_valid_q || data_out_ready;
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: packet framing driven by accepted sop/eop beats.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_fire_s && data_in_sop) begin
               state_d = data_in_eop ? ST_FLUSH : ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (in_fire_s && data_in_eop) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (pop_last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: which beats are appended and which words are popped.
   always_comb begin
      push_s     = 1'b0;
      sop_set_s  = 1'b0;
      pop_full_s = slot_free_s &&
                   ((cnt_q > WORD_BITS) ||
                    ((cnt_q == WORD_BITS) && (state_q != ST_FLUSH)));
      pop_last_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Only a sop beat opens a packet; anything else is dropped.
            push_s    = in_fire_s && data_in_sop;
            sop_set_s = in_fire_s && data_in_sop;
         end
         ST_RUN: begin
            // A stray sop here is just another continuation beat.
            push_s    = in_fire_s;
         end
         ST_FLUSH: begin
            pop_last_s = slot_free_s && (cnt_q <= WORD_BITS);
         end
         default: begin
            push_s     = 1'b0;
            sop_set_s  = 1'b0;
            pop_last_s = 1'b0;
         end
      endcase
      load_s = pop_full_s || pop_last_s;
   end

   // Buffer update: pop the top bits first, then append below what remains.
   always_comb begin
      if (pop_full_s) begin
         pop_n_s = WORD_BITS;
      end else if (pop_last_s) begin
         pop_n_s = cnt_q;
      end else begin
         pop_n_s = 6'd0;
      end
      if (push_s) begin
         push_n_s = {1'b0, vb_clamp_s};
      end else begin
         push_n_s = 6'd0;
      end
      cnt_rem_s = cnt_q - pop_n_s;
      buf_rem_s = buf_q << pop_n_s;
      in_ext_s  = {in_bits_s, {(BUF_W-16){1'b0}}} >> cnt_rem_s;
      if (push_s) begin
         buf_d = buf_rem_s | in_ext_s;
      end else begin
         buf_d = buf_rem_s;
      end
      cnt_d = cnt_rem_s + push_n_s;
      if (sop_set_s) begin
         first_d = 1'b1;
      end else if (load_s) begin
         first_d = 1'b0;
      end else begin
         first_d = first_q;
      end
   end

   // Output word next value: loads whenever the slot is free.
   always_comb begin
      word_top_s   = buf_q[BUF_W-1 -: OUT_W];
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      dout_sop_d   = dout_sop_q;
      dout_eop_d   = dout_eop_q;
      dout_vb_d    = dout_vb_q;
      if (slot_free_s) begin
         if (pop_full_s) begin
            dout_d       = word_top_s;
            dout_valid_d = 1'b1;
            dout_sop_d   = first_q;
            dout_eop_d   = 1'b0;
            dout_vb_d    = 4'(OUT_W);
         end else if (pop_last_s) begin
            dout_d       = word_top_s & top_mask(cnt_q);
            dout_valid_d = 1'b1;
            dout_sop_d   = first_q;
            dout_eop_d   = 1'b1;
            dout_vb_d    = cnt_q[3:0];
         end else begin
            dout_d       = {OUT_W{1'b0}};
            dout_valid_d = 1'b0;
            dout_sop_d   = 1'b0;
            dout_eop_d   = 1'b0;
            dout_vb_d    = 4'd0;
         end
      end else begin
         dout_valid_d = dout_valid_q;
      end
   end

   // Buffer, bit count and output word registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q        <= 6'd0;
         buf_q        <= {BUF_W{1'b0}};
         first_q      <= 1'b0;
         dout_q       <= {OUT_W{1'b0}};
         dout_valid_q <= 1'b0;
         dout_sop_q   <= 1'b0;
         dout_eop_q   <= 1'b0;
         dout_vb_q    <= 4'd0;
      end else begin
         cnt_q        <= cnt_d;
         buf_q        <= buf_d;
         first_q      <= first_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_sop_q   <= dout_sop_d;
         dout_eop_q   <= dout_eop_d;
         dout_vb_q    <= dout_vb_d;
      end
   end

   assign data_in_ready       = in_ready_s;
   assign data_out            = dout_q;
   assign data_out_valid      = dout_valid_q;
   assign data_out_sop        = dout_sop_q;
   assign data_out_eop        = dout_eop_q;
   assign data_out_valid_bits = dout_vb_q;

`ifdef CVT16TO9_STATS_EN
   logic [15:0] pkt_q;
   logic [15:0] err_q;
   logic        pkt_event_s;
   logic        err_event_s;

   // Statistic events: completed packets and framing anomalies.
   always_comb begin
      pkt_event_s = dout_valid_q && dout_eop_q && data_out_ready;
      if (in_fire_s) begin
         err_event_s = ((state_q == ST_IDLE) && !data_in_sop) ||
                       ((state_q == ST_RUN) && data_in_sop);
      end else begin
         err_event_s = 1'b0;
      end
   end

   // Wrapping statistic counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pkt_q <= 16'd0;
         err_q <= 16'd0;
      end else begin
         pkt_q <= pkt_q + {15'd0, pkt_event_s};
         err_q <= err_q + {15'd0, err_event_s};
      end
   end

   assign pkt_cnt = pkt_q;
   assign err_cnt = err_q;
`endif

endmodule

// File: doc/cvt16to9.md
Name: cvt16to9

Overview:
Downstream stage of the 9-to-16 width converter: repacks a 16-bit, bit-count-qualified packet stream into 9-bit output words.
- Accumulates valid input bits MSB-first in a 32-bit buffer and emits full 9-bit words.
- Emits one final partial word at end-of-packet.
- Valid/ready handshake on both sides, so input is throttled to the 9-bit output rate.

Parameters:
BUF_W, 32, accumulator width in bits; must be >= 32.
OUT_W, 9, output word width; fixed at 9 in this revision.

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
data_in  input  16  input bits, MSB-first; valid bits are data_in[15 -: data_in_valid_bits]
data_in_valid  input  1  input beat present
data_in_sop  input  1  first beat of packet
data_in_eop  input  1  last beat of packet
data_in_valid_bits  input  5  number of valid bits, 0..16; values >16 clamp to 16
data_in_ready  output  1  beat accepted when data_in_valid & data_in_ready
data_out  output  9  output bits, MSB-aligned; unused low bits zero
data_out_valid  output  1  output word present
data_out_ready  input  1  downstream accepts word
data_out_sop  output  1  first output word of packet
data_out_eop  output  1  last output word of packet
data_out_valid_bits  output  4  valid bits in data_out, 0..9

Behaviour:
Reset and buffer:
- Reset values: all outputs 0, except data_in_ready = 1. Reset state IDLE, cnt = 0, buffer cleared.
- Reset mid-packet discards all buffered bits and any pending output word immediately.
- Buffer holds cnt valid bits at buf[BUF_W-1 -: cnt]; cnt is 6 bits, range 0..32.

States:
- IDLE
  - sop beat accepted: go to RUN, or to FLUSH if eop is also set.
  - Beat without sop: accepted and dropped.
- RUN
  - Beat with eop accepted: go to FLUSH.
  - sop inside RUN is ignored; the beat is treated as a continuation.
- FLUSH
  - Back to IDLE on the edge that loads the eop word into the output register.

Input side:
- data_in_ready = (state != FLUSH) && (cnt <= 16); registered cnt only, no combinational path from data_out_ready.
- An accepted beat appends its valid bits directly below the existing cnt bits.
- valid_bits = 0 beats append nothing, but sop/eop still act.

Output side:
- The output register loads when slot free = !data_out_valid || data_out_ready.
- Load rules when the slot is free:
  - cnt > 9, or cnt == 9 and not FLUSH: emit the top 9 bits, valid_bits = 9, eop = 0.
  - FLUSH and 1 <= cnt <= 9: emit cnt bits left-aligned, valid_bits = cnt, eop = 1.
  - FLUSH and cnt == 0 (empty packet): emit valid_bits = 0, data 0, eop = 1.
- If the slot is free and nothing qualifies, data_out_valid drops to 0.
- data_out_sop = 1 on the first word emitted after the packet's sop; for empty packets sop and eop are both 1.
- Push and pop in the same cycle: pop the top bits first, then append after the remaining bits. New cnt = cnt - popped + pushed.
- Latency: a beat accepted at edge E0 is visible in cnt after E0; the earliest word containing it is valid after E1.
- Outputs hold stable while data_out_valid && !data_out_ready.

Optional Feature:
Macro CVT16TO9_STATS_EN.
- Defined: adds outputs pkt_cnt[15:0] and err_cnt[15:0], both reset to 0 and wrapping at 0xFFFF.
  - pkt_cnt increments on each eop word handshake at the output.
  - err_cnt increments on each accepted beat dropped in IDLE (no sop) and on each sop seen in RUN.
- Undefined: neither port nor counter exists; datapath behaviour is identical.

Test Plan:
1. Packet 0xABCD (16 bits, sop), then 0x1234 (16 bits, eop), data_out_ready = 1 -> four words:
   - 0x157/9, sop = 1
   - 0x134/9
   - 0x091/9
   - 0x140/5, eop = 1
2. Same packet with data_out_ready low for 5 cycles after the first word -> data_out held at 0x157 with sop = 1; data_in_ready low once cnt > 16; no bits lost or duplicated.
3. Single beat, sop = eop = 1, valid_bits = 0 -> one word: valid_bits 0, data 0, sop = eop = 1; state back to IDLE.
4. Beat 0xFFFF without sop in IDLE, then a 9-bit sop/eop beat 0xFF80 -> first beat dropped; one word 0x1FF/9 with sop = eop = 1; with STATS_EN, err_cnt = 1 and pkt_cnt = 1.
5. Eight 9-bit beats in one packet, ready always high -> eight 9-bit words equal to the inputs; last word has eop; sustained output valid every cycle once started.
6. rstn low for 1 cycle mid-packet with cnt = 20 -> all outputs 0, data_in_ready = 1, state IDLE; a following fresh packet converts correctly.
